job_load_monitor: RTL and testbench

//  Upstream monitoring stage for the DVFS controller. Tracks job-queue depth from push/pop

---
 rtl/job_load_monitor_pkg.sv | 16 +
 rtl/job_load_monitor_if.sv | 28 ++
 rtl/job_load_monitor_ema.sv | 45 ++++
 rtl/job_load_monitor.sv | 110 +++++++++++
 tb/tb_job_load_monitor.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/job_load_monitor_pkg.sv
// Shared constants for the job-load monitor and the downstream DVFS controller.
// The occupancy width and thresholds must stay in step with dvfs_controller.
package job_load_monitor_pkg;

  localparam int OCC_W       = 8;
  localparam int THRESH_LOW  = 60;
  localparam int THRESH_HIGH = 128;

  typedef enum logic [1:0] {
    DVFS_LOW        = 2'b00,
    DVFS_NORMAL     = 2'b01,
    DVFS_HIGH       = 2'b10,
    DVFS_TRANSITION = 2'b11
  } dvfs_state_e;

endpackage

// File: rtl/job_load_monitor_if.sv
// Scheduler-side strobes in, smoothed load and status out.
// Handshake: push/pop/clear/hold are per-cycle strobes with no back-pressure; occ_valid is
// a one-cycle qualifier for job_queue_occupancy with no ready, so the consumer must sample it that cycle.
interface job_load_if
  import job_load_monitor_pkg::*;
#(
  parameter int DEPTH_W = 10
);
  logic               push;
  logic               pop;
  logic               clear;
  logic               hold;
  logic [OCC_W-1:0]   job_queue_occupancy;
  logic               occ_valid;
  logic [DEPTH_W-1:0] depth;
  logic               overflow_err;
  logic               underflow_err;

  modport master (
    output push, pop, clear, hold,
    input  job_queue_occupancy, occ_valid, depth, overflow_err, underflow_err
  );

  modport slave (
    input  push, pop, clear, hold,
    output job_queue_occupancy, occ_valid, depth, overflow_err, underflow_err
  );
endinterface

// File: rtl/job_load_monitor_ema.sv
// Exponential moving average of the queue depth, updated only on sample ticks.
// avg_step_o is the value avg would take on a tick, so the top can publish it on the same edge.
module load_ema_filter #(
  parameter int DEPTH_W   = 10,
  parameter int EMA_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               tick_i,
  input  logic [DEPTH_W-1:0] sample_i,
  output logic [DEPTH_W-1:0] avg_o,
  output logic [DEPTH_W-1:0] avg_step_o
);
  localparam int DW = DEPTH_W + 2;
  localparam logic signed [DW-1:0] MAX_S = {2'b00, {DEPTH_W{1'b1}}};
  localparam logic signed [DW-1:0] ONE_S = {{(DW-1){1'b0}}, 1'b1};

  logic [DEPTH_W-1:0]   avg_q, avg_d;
  logic signed [DW-1:0] diff, step, sum;

  always_comb begin
    diff = $signed({2'b00, sample_i}) - $signed({2'b00, avg_q});
    step = diff >>> EMA_SHIFT;
    // Floor division stalls a rising average just below the sample; nudge it the last step.
    if (diff != '0 && step == '0) step = ONE_S;
    sum = $signed({2'b00, avg_q}) + step;
    if (sum[DW-1])       avg_step_o = '0;
    else if (sum > MAX_S) avg_step_o = '1;
    else                  avg_step_o = sum[DEPTH_W-1:0];
  end

  always_comb begin
    avg_d = avg_q;
    if (clear_i)     avg_d = '0;
    else if (tick_i) avg_d = avg_step_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) avg_q <= '0;
    else        avg_q <= avg_d;
  end

  assign avg_o = avg_q;
endmodule

// File: rtl/job_load_monitor.sv
// Tracks job-queue depth from push/pop strobes and publishes a periodically
// smoothed 8-bit load for the DVFS controller, deferring updates while it is busy.
module job_load_monitor
  import job_load_monitor_pkg::*;
#(
  parameter int DEPTH_W       = 10,
  parameter int SAMPLE_PERIOD = 64,
  parameter int EMA_SHIFT     = 2
) (
  input logic       clk,
  input logic       rst_n,
  job_load_if.slave mon_if
);
  localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
  localparam logic [DEPTH_W-1:0] MAX_DEPTH  = '1;

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d, unf_q, unf_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               occ_valid_q, occ_valid_d;
  logic               pending_q, pending_d;
  logic               tick;
  logic [DEPTH_W-1:0] avg_q, avg_step;

  assign tick    = (timer_q == TIMER_LAST);
  assign timer_d = tick ? '0 : timer_q + TIMER_W'(1);

  load_ema_filter #(
    .DEPTH_W   (DEPTH_W),
    .EMA_SHIFT (EMA_SHIFT)
  ) u_ema (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (mon_if.clear),
    .tick_i     (tick),
    .sample_i   (depth_q),
    .avg_o      (avg_q),
    .avg_step_o (avg_step)
  );

  // Simultaneous push and pop is a pass-through and never an error, even at the limits.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (mon_if.push && !mon_if.pop) begin
      if (depth_q == MAX_DEPTH) ovf_d   = 1'b1;
      else                      depth_d = depth_q + DEPTH_W'(1);
    end else if (mon_if.pop && !mon_if.push) begin
      if (depth_q == '0) unf_d   = 1'b1;
      else               depth_d = depth_q - DEPTH_W'(1);
    end
  end

  // A tick under hold is remembered and published on the first unheld cycle.
  always_comb begin
    occ_d       = occ_q;
    occ_valid_d = 1'b0;
    pending_d   = pending_q;
    if (tick) begin
      if (!mon_if.hold) begin
        occ_d       = avg_step[DEPTH_W-1 -: OCC_W];
        occ_valid_d = 1'b1;
        pending_d   = 1'b0;
      end else begin
        pending_d   = 1'b1;
      end
    end else if (pending_q && !mon_if.hold) begin
      occ_d       = avg_q[DEPTH_W-1 -: OCC_W];
      occ_valid_d = 1'b1;
      pending_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      timer_q     <= '0;
      occ_q       <= '0;
      occ_valid_q <= 1'b0;
      pending_q   <= 1'b0;
    end else if (mon_if.clear) begin
      depth_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      timer_q     <= '0;
      occ_q       <= '0;
      occ_valid_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      timer_q     <= timer_d;
      occ_q       <= occ_d;
      occ_valid_q <= occ_valid_d;
      pending_q   <= pending_d;
    end
  end

  assign mon_if.depth               = depth_q;
  assign mon_if.overflow_err        = ovf_q;
  assign mon_if.underflow_err       = unf_q;
  assign mon_if.job_queue_occupancy = occ_q;
  assign mon_if.occ_valid           = occ_valid_q;
endmodule

// File: tb/tb_job_load_monitor.sv
// Bench for job_load_monitor: directed scenarios plus randomized push/pop/hold/clear,
// checked every cycle against an arithmetic model of queue depth and the sampled EMA.
module tb_job_load_monitor;
  import job_load_monitor_pkg::*;

  localparam int DEPTH_W = 10;
  localparam int SP      = 64;
  localparam int SH      = 2;
  localparam int MAXD    = (1 << DEPTH_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  job_load_if #(.DEPTH_W(DEPTH_W)) mon_if ();

  job_load_monitor #(
    .DEPTH_W       (DEPTH_W),
    .SAMPLE_PERIOD (SP),
    .EMA_SHIFT     (SH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mon_if (mon_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_depth = 0, m_avg = 0, m_timer = 0, m_occ = 0;
  bit  m_valid = 0, m_pend = 0, m_ovf = 0, m_unf = 0;
  logic [OCC_W-1:0] exp_q[$];

  function automatic int ema_next(input int avg, input int sample);
    int diff, step, r;
    diff = sample - avg;
    if (diff >= 0) step = diff / (1 << SH);
    else           step = -((-diff + (1 << SH) - 1) / (1 << SH));
    if (diff != 0 && step == 0) step = 1;
    r = avg + step;
    if (r < 0)    r = 0;
    if (r > MAXD) r = MAXD;
    return r;
  endfunction

  task automatic model_zero();
    m_depth = 0; m_avg = 0; m_timer = 0; m_occ = 0;
    m_valid = 0; m_pend = 0; m_ovf = 0; m_unf = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || mon_if.clear) begin
      model_zero();
      exp_q.delete();
    end else begin
      bit tick;
      tick = (m_timer == SP - 1);
      if (tick) m_avg = ema_next(m_avg, m_depth);
      if (mon_if.push && !mon_if.pop) begin
        if (m_depth == MAXD) m_ovf = 1; else m_depth++;
      end else if (mon_if.pop && !mon_if.push) begin
        if (m_depth == 0) m_unf = 1; else m_depth--;
      end
      m_valid = 0;
      if ((tick || m_pend) && !mon_if.hold) begin
        m_occ   = m_avg >> (DEPTH_W - OCC_W);
        m_valid = 1;
        m_pend  = 0;
        exp_q.push_back(OCC_W'(m_occ));
      end else if (tick) begin
        m_pend = 1;
      end
      m_timer = (m_timer + 1) % SP;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("depth",         32'(mon_if.depth),               32'(m_depth));
      chk("occ_valid",     32'(mon_if.occ_valid),           32'(m_valid));
      chk("occupancy",     32'(mon_if.job_queue_occupancy), 32'(m_occ));
      chk("overflow_err",  32'(mon_if.overflow_err),        32'(m_ovf));
      chk("underflow_err", 32'(mon_if.underflow_err),       32'(m_unf));
      if (mon_if.occ_valid === 1'b1) begin
        chk("occ_expected_present", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0)
          chk("occ_published_value", 32'(mon_if.job_queue_occupancy), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit p, input bit po, input bit h, input bit c);
    mon_if.push  = p;
    mon_if.pop   = po;
    mon_if.hold  = h;
    mon_if.clear = c;
    @(negedge clk);
  endtask

  task automatic cycles_to_valid(input string name);
    int cnt;
    cnt = 0;
    do begin
      drive(0, 0, 0, 0);
      cnt++;
    end while (mon_if.occ_valid !== 1'b1 && cnt < 200);
    chk(name, 32'(cnt), 32'd64);
  endtask

  initial begin
    int prev, last_t, nvalid, frozen, mode;
    mon_if.push = 0; mon_if.pop = 0; mon_if.hold = 0; mon_if.clear = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_depth", 32'(mon_if.depth), 32'd0);
    chk("reset_occ",   32'(mon_if.job_queue_occupancy), 32'd0);
    chk("reset_valid", 32'(mon_if.occ_valid), 32'd0);

    // Reset mid-run at depth 300
    for (int i = 0; i < 300; i++) drive(1, 0, 0, 0);
    chk("s1_depth_before_reset", 32'(mon_if.depth), 32'd300);
    #2 rst_n = 1'b0;
    #1;
    chk("s1_async_depth", 32'(mon_if.depth), 32'd0);
    chk("s1_async_occ",   32'(mon_if.job_queue_occupancy), 32'd0);
    chk("s1_async_errs",  32'({mon_if.overflow_err, mon_if.underflow_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles_to_valid("s1_first_valid_latency");

    // Push to 512 and hold depth constant: converge to occupancy 128
    drive(0, 0, 0, 1);
    for (int i = 0; i < 512; i++) drive(1, 0, 0, 0);
    chk("s2_depth", 32'(mon_if.depth), 32'd512);
    prev = -1; last_t = -1;
    for (int t = 0; t < 45 * SP; t++) begin
      drive(0, 0, 0, 0);
      if (mon_if.occ_valid === 1'b1) begin
        chk("s2_monotonic", 32'(int'(mon_if.job_queue_occupancy) >= prev), 32'd1);
        if (last_t >= 0) chk("s2_valid_spacing", 32'(t - last_t), 32'd64);
        prev = mon_if.job_queue_occupancy;
        last_t = t;
      end
    end
    chk("s2_converged_occ", 32'(mon_if.job_queue_occupancy), 32'd128);

    // Overflow on the 1024th push
    drive(0, 0, 0, 1);
    drive(1, 1, 0, 0);
    chk("s3_pushpop_at_0_depth", 32'(mon_if.depth), 32'd0);
    chk("s3_pushpop_at_0_unf",   32'(mon_if.underflow_err), 32'd0);
    for (int i = 1; i <= 1030; i++) begin
      drive(1, 0, 0, 0);
      if (i == 1023) chk("s3_no_ovf_at_1023", 32'(mon_if.overflow_err), 32'd0);
      if (i == 1024) chk("s3_ovf_at_1024",    32'(mon_if.overflow_err), 32'd1);
    end
    chk("s3_depth_saturated", 32'(mon_if.depth), 32'd1023);
    chk("s3_no_underflow",    32'(mon_if.underflow_err), 32'd0);

    // push&pop at max, lone pop at 0
    drive(0, 0, 0, 1);
    for (int i = 0; i < MAXD; i++) drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    chk("s4_pushpop_at_max_depth", 32'(mon_if.depth), 32'd1023);
    chk("s4_pushpop_at_max_ovf",   32'(mon_if.overflow_err), 32'd0);
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    chk("s4_lone_pop_unf",   32'(mon_if.underflow_err), 32'd1);
    chk("s4_lone_pop_depth", 32'(mon_if.depth), 32'd0);

    // hold across three ticks
    drive(0, 0, 0, 1);
    for (int i = 0; i < 200; i++) drive(1, 0, 0, 0);
    while (m_timer != 0) drive(0, 0, 0, 0);
    frozen = mon_if.job_queue_occupancy;
    nvalid = 0;
    for (int i = 0; i < 3 * SP; i++) begin
      drive(1'($urandom_range(0, 1)), 0, 1, 0);
      if (mon_if.occ_valid === 1'b1) nvalid++;
    end
    chk("s5_no_valid_while_held", 32'(nvalid), 32'd0);
    chk("s5_occ_frozen", 32'(mon_if.job_queue_occupancy), 32'(frozen));
    drive(0, 0, 0, 0);
    chk("s5_release_pulse", 32'(mon_if.occ_valid), 32'd1);
    drive(0, 0, 0, 0);
    chk("s5_single_pulse", 32'(mon_if.occ_valid), 32'd0);

    // clear at timer 30 with depth 700
    drive(0, 0, 0, 1);
    for (int i = 0; i < 700; i++) drive(1, 0, 0, 0);
    chk("s6_depth", 32'(mon_if.depth), 32'd700);
    for (int i = 0; i < 2 * SP && m_timer != 30; i++) drive(0, 0, 0, 0);
    chk("s6_timer_reached_30", 32'(m_timer), 32'd30);
    drive(0, 0, 0, 1);
    chk("s6_clear_depth", 32'(mon_if.depth), 32'd0);
    chk("s6_clear_occ",   32'(mon_if.job_queue_occupancy), 32'd0);
    chk("s6_clear_ovf",   32'(mon_if.overflow_err), 32'd0);
    cycles_to_valid("s6_tick_after_clear");

    // randomized traffic in push-heavy, pop-heavy and balanced phases
    mode = 0;
    for (int i = 0; i < 15000; i++) begin
      bit p, po, h, c;
      if (i % 800 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       begin p = ($urandom_range(0, 99) < 80); po = ($urandom_range(0, 99) < 20); end
        1:       begin p = ($urandom_range(0, 99) < 20); po = ($urandom_range(0, 99) < 80); end
        default: begin p = ($urandom_range(0, 99) < 50); po = ($urandom_range(0, 99) < 50); end
      endcase
      if ($urandom_range(0, 99) < 2) h = ~mon_if.hold; else h = mon_if.hold;
      c = ($urandom_range(0, 2999) == 0);
      drive(p, po, h, c);
    end
    drive(0, 0, 0, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
